// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI bridge: write FSM encoding and
// the fixed AXI attribute values driven on every transaction.
package sram_axi_bridge_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    localparam logic [3:0] DEF_INST_ID    = 4'd0;
    localparam logic [3:0] DEF_DATA_ID    = 4'd1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

endpackage

// File: rtl/sram_axi_bridge.sv
// Converts the core's instruction and data SRAM-style ports into single-beat
// AXI transactions; at most one transaction is outstanding per port.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = DEF_INST_ID,
    parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    logic        ar_pend_q, ar_pend_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [3:0]  ar_id_q, ar_id_d;
    logic [1:0]  ar_size_q, ar_size_d;
    logic        inst_out_q, inst_out_d;
    logic        data_rd_out_q, data_rd_out_d;
    logic        inst_ok_q, inst_ok_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    wstate_t     wstate_q, wstate_d;
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [1:0]  aw_size_q, aw_size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic data_rd_busy, data_rd_acc, data_wr_acc, inst_acc;
    logic r_inst_hit, r_data_hit, b_hit;

    // Fields that carry no meaning for this bridge: reads only on the
    // instruction port, and AXI response codes are not reported back.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bresp};

    always_comb begin
        data_rd_busy = data_rd_out_q | (ar_pend_q & (ar_id_q == DATA_ID));
        data_rd_acc  = resetn & data_sram_req & ~data_sram_wr & ~ar_pend_q
                     & ~data_rd_out_q & (wstate_q == W_IDLE);
        data_wr_acc  = resetn & data_sram_req & data_sram_wr
                     & (wstate_q == W_IDLE) & ~data_rd_busy;
        data_sram_addr_ok = data_rd_acc | data_wr_acc;
        // Data port has priority over the instruction port for the AR slot.
        inst_acc = resetn & inst_sram_req & ~ar_pend_q & ~inst_out_q & ~data_sram_addr_ok;
        inst_sram_addr_ok = inst_acc;

        r_inst_hit = rvalid & (rid == INST_ID) & inst_out_q;
        r_data_hit = rvalid & (rid == DATA_ID) & data_rd_out_q;
        b_hit      = (wstate_q == W_RESP) & bvalid & (bid == DATA_ID);

        ar_pend_d     = ar_pend_q;
        ar_addr_d     = ar_addr_q;
        ar_id_d       = ar_id_q;
        ar_size_d     = ar_size_q;
        inst_out_d    = inst_out_q;
        data_rd_out_d = data_rd_out_q;
        inst_ok_d     = r_inst_hit;
        inst_rdata_d  = r_inst_hit ? rdata : inst_rdata_q;
        data_ok_d     = r_data_hit | b_hit;
        data_rdata_d  = r_data_hit ? rdata : data_rdata_q;
        wstate_d      = wstate_q;
        aw_pend_d     = aw_pend_q;
        w_pend_d      = w_pend_q;
        aw_addr_d     = aw_addr_q;
        aw_size_d     = aw_size_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;

        if (ar_pend_q && arready) begin
            ar_pend_d = 1'b0;
            if (ar_id_q == INST_ID) inst_out_d    = 1'b1;
            else                    data_rd_out_d = 1'b1;
        end
        if (r_inst_hit) inst_out_d    = 1'b0;
        if (r_data_hit) data_rd_out_d = 1'b0;

        if (inst_acc) begin
            ar_pend_d = 1'b1;
            ar_addr_d = inst_sram_addr;
            ar_id_d   = INST_ID;
            ar_size_d = inst_sram_size;
        end else if (data_rd_acc) begin
            ar_pend_d = 1'b1;
            ar_addr_d = data_sram_addr;
            ar_id_d   = DATA_ID;
            ar_size_d = data_sram_size;
        end

        case (wstate_q)
            W_IDLE: if (data_wr_acc) begin
                wstate_d  = W_SEND;
                aw_pend_d = 1'b1;
                w_pend_d  = 1'b1;
                aw_addr_d = data_sram_addr;
                aw_size_d = data_sram_size;
                wdata_d   = data_sram_wdata;
                wstrb_d   = data_sram_wstrb;
            end
            W_SEND: begin
                if (aw_pend_q && awready) aw_pend_d = 1'b0;
                if (w_pend_q && wready)   w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) wstate_d = W_RESP;
            end
            W_RESP: if (b_hit) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_pend_q     <= 1'b0;
            ar_addr_q     <= '0;
            ar_id_q       <= '0;
            ar_size_q     <= '0;
            inst_out_q    <= 1'b0;
            data_rd_out_q <= 1'b0;
            inst_ok_q     <= 1'b0;
            inst_rdata_q  <= '0;
            data_ok_q     <= 1'b0;
            data_rdata_q  <= '0;
            wstate_q      <= W_IDLE;
            aw_pend_q     <= 1'b0;
            w_pend_q      <= 1'b0;
            aw_addr_q     <= '0;
            aw_size_q     <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            ar_pend_q     <= ar_pend_d;
            ar_addr_q     <= ar_addr_d;
            ar_id_q       <= ar_id_d;
            ar_size_q     <= ar_size_d;
            inst_out_q    <= inst_out_d;
            data_rd_out_q <= data_rd_out_d;
            inst_ok_q     <= inst_ok_d;
            inst_rdata_q  <= inst_rdata_d;
            data_ok_q     <= data_ok_d;
            data_rdata_q  <= data_rdata_d;
            wstate_q      <= wstate_d;
            aw_pend_q     <= aw_pend_d;
            w_pend_q      <= w_pend_d;
            aw_addr_q     <= aw_addr_d;
            aw_size_q     <= aw_size_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
        end
    end

    assign inst_sram_data_ok = inst_ok_q;
    assign inst_sram_rdata   = inst_rdata_q;
    assign data_sram_data_ok = data_ok_q;
    assign data_sram_rdata   = data_rdata_q;

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = {1'b0, ar_size_q};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = ar_pend_q;
    assign rready  = 1'b1;

    assign awid    = DATA_ID;
    assign awaddr  = aw_addr_q;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = {1'b0, aw_size_q};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = aw_pend_q;
    assign wid     = DATA_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = w_pend_q;
    assign bready  = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: scenario tasks drive the core and
// AXI sides by hand; a scoreboard checks every data_ok return and AR beat.
module tb_sram_axi_bridge;

    logic        clk, resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int errors = 0;
    int checks = 0;
    logic [31:0] inst_exp[$];
    logic [31:0] data_exp[$];
    logic [38:0] ar_exp[$];
    logic [31:0] last_data_rdata = 32'h0;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_r(input logic [3:0] id, input logic [31:0] d);
        rvalid = 1'b1; rid = id; rdata = d;
        tick();
        rvalid = 1'b0; rid = 4'hF; rdata = 32'h0;
    endtask

    task automatic monitor();
        logic [31:0] e;
        logic [38:0] a;
        forever begin
            @(negedge clk);
            if (inst_sram_data_ok) begin
                checks++;
                if (inst_exp.size() == 0) begin
                    errors++;
                    $display("FAIL inst_data_ok: unexpected pulse rdata=%h, required no pulse", inst_sram_rdata);
                end else begin
                    e = inst_exp.pop_front();
                    if (inst_sram_rdata !== e) begin
                        errors++;
                        $display("FAIL inst_rdata: got %h required %h", inst_sram_rdata, e);
                    end else $display("inst return rdata=%h ok", inst_sram_rdata);
                end
            end
            if (data_sram_data_ok) begin
                checks++;
                if (data_exp.size() == 0) begin
                    errors++;
                    $display("FAIL data_data_ok: unexpected pulse rdata=%h, required no pulse", data_sram_rdata);
                end else begin
                    e = data_exp.pop_front();
                    if (data_sram_rdata !== e) begin
                        errors++;
                        $display("FAIL data_rdata: got %h required %h", data_sram_rdata, e);
                    end else $display("data return rdata=%h ok", data_sram_rdata);
                end
            end
            if (arvalid && arready) begin
                checks++;
                if (ar_exp.size() == 0) begin
                    errors++;
                    $display("FAIL ar_beat: unexpected id=%h addr=%h, required none", arid, araddr);
                end else begin
                    a = ar_exp.pop_front();
                    if ({arid, araddr, arsize} !== a) begin
                        errors++;
                        $display("FAIL ar_beat: got %h required %h", {arid, araddr, arsize}, a);
                    end else $display("AR beat id=%h addr=%h size=%0d ok", arid, araddr, arsize);
                end
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (inst_exp.size() == 0 && data_exp.size() == 0 && ar_exp.size() == 0) break;
            tick();
        end
        checks++;
        if (inst_exp.size() != 0 || data_exp.size() != 0 || ar_exp.size() != 0) begin
            errors++;
            $display("FAIL %s drain: pending inst=%0d data=%0d ar=%0d, required 0/0/0",
                     name, inst_exp.size(), data_exp.size(), ar_exp.size());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        inst_sram_req = 1'b1; data_sram_req = 1'b1;
        tick(); tick();
        checks++;
        if ({arvalid, awvalid, wvalid, inst_sram_addr_ok, data_sram_addr_ok,
             inst_sram_data_ok, data_sram_data_ok} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000", {arvalid, awvalid, wvalid,
                     inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
        end
        checks++;
        if ({inst_sram_rdata, data_sram_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 0", {inst_sram_rdata, data_sram_rdata});
        end
        checks++;
        if ({arlen, awlen, arburst, awburst, arlock, awlock, arcache, awcache, arprot, awprot,
             wlast, awid, wid, rready, bready} !== {8'd0, 8'd0, 2'b01, 2'b01, 2'b0, 2'b0, 4'b0, 4'b0,
             3'b0, 3'b0, 1'b1, 4'd1, 4'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL constants: got lens=%h/%h burst=%b/%b wlast=%b awid=%h wid=%h rready=%b bready=%b",
                     arlen, awlen, arburst, awburst, wlast, awid, wid, rready, bready);
        end
        $display("reset check done");
        inst_sram_req = 1'b0; data_sram_req = 1'b0;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_inst_read();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2;
        inst_sram_wr = 1'b1;
        #1;
        checks++;
        if (inst_sram_addr_ok !== 1'b1) begin
            errors++; $display("FAIL inst_addr_ok: got %b required 1", inst_sram_addr_ok);
        end
        ar_exp.push_back({4'd0, 32'h1C00_0000, 3'd2});
        inst_exp.push_back(32'h0280_0C0C);
        tick();
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
        checks++;
        if (arvalid !== 1'b1) begin
            errors++; $display("FAIL inst_arvalid_rise: got %b required 1", arvalid);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++;
        if (arvalid !== 1'b0) begin
            errors++; $display("FAIL inst_arvalid_clear: got %b required 0", arvalid);
        end
        tick(); tick();
        send_r(4'd0, 32'h0280_0C0C);
        drain("inst_read");
    endtask

    task automatic test_dual_read();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0100; inst_sram_size = 2'd2;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_1000; data_sram_size = 2'd2;
        #1;
        checks++;
        if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10) begin
            errors++; $display("FAIL dual_priority: got data/inst=%b required 10",
                               {data_sram_addr_ok, inst_sram_addr_ok});
        end
        ar_exp.push_back({4'd1, 32'h0000_1000, 3'd2});
        data_exp.push_back(mem_word(32'h0000_1000));
        tick();
        data_sram_req = 1'b0;
        checks++;
        if (inst_sram_addr_ok !== 1'b0) begin
            errors++; $display("FAIL dual_slot_busy: got %b required 0", inst_sram_addr_ok);
        end
        arready = 1'b1;
        tick();
        checks++;
        if (inst_sram_addr_ok !== 1'b1) begin
            errors++; $display("FAIL dual_inst_accept: got %b required 1", inst_sram_addr_ok);
        end
        ar_exp.push_back({4'd0, 32'h1C00_0100, 3'd2});
        inst_exp.push_back(mem_word(32'h1C00_0100));
        tick();
        inst_sram_req = 1'b0;
        tick();
        arready = 1'b0;
        send_r(4'd0, mem_word(32'h1C00_0100));
        send_r(4'd1, mem_word(32'h0000_1000));
        last_data_rdata = mem_word(32'h0000_1000);
        drain("dual_read");
    endtask

    task automatic test_write_then_read();
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd1;
        data_sram_wstrb = 4'b0011; data_sram_addr = 32'h8000_0010; data_sram_wdata = 32'h1234_5678;
        #1;
        checks++;
        if (data_sram_addr_ok !== 1'b1) begin
            errors++; $display("FAIL wr_addr_ok: got %b required 1", data_sram_addr_ok);
        end
        tick();
        data_sram_req = 1'b0; data_sram_wr = 1'b0;
        checks++;
        if ({awvalid, wvalid, awaddr, awsize, wstrb, wdata, awid} !==
            {1'b1, 1'b1, 32'h8000_0010, 3'd1, 4'b0011, 32'h1234_5678, 4'd1}) begin
            errors++;
            $display("FAIL wr_channels: got awv=%b wv=%b addr=%h size=%0d strb=%b data=%h id=%h required 1 1 80000010 1 0011 12345678 1",
                     awvalid, wvalid, awaddr, awsize, wstrb, wdata, awid);
        end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        checks++;
        if ({awvalid, wvalid} !== 2'b01) begin
            errors++; $display("FAIL wr_aw_drop: got awv/wv=%b required 01", {awvalid, wvalid});
        end
        tick();
        checks++;
        if ({awvalid, wvalid} !== 2'b01) begin
            errors++; $display("FAIL wr_w_hold: got awv/wv=%b required 01", {awvalid, wvalid});
        end
        wready = 1'b1;
        tick();
        wready = 1'b0;
        checks++;
        if ({awvalid, wvalid} !== 2'b00) begin
            errors++; $display("FAIL wr_w_drop: got awv/wv=%b required 00", {awvalid, wvalid});
        end
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_2000; data_sram_size = 2'd2;
        #1;
        checks++;
        if (data_sram_addr_ok !== 1'b0) begin
            errors++; $display("FAIL rd_in_resp_0: got %b required 0", data_sram_addr_ok);
        end
        tick();
        bvalid = 1'b1; bid = 4'd1;
        data_exp.push_back(last_data_rdata);
        #1;
        checks++;
        if (data_sram_addr_ok !== 1'b0) begin
            errors++; $display("FAIL rd_in_resp_1: got %b required 0", data_sram_addr_ok);
        end
        tick();
        bvalid = 1'b0; bid = 4'hF;
        checks++;
        if (data_sram_addr_ok !== 1'b1) begin
            errors++; $display("FAIL rd_after_resp: got %b required 1", data_sram_addr_ok);
        end
        ar_exp.push_back({4'd1, 32'h0000_2000, 3'd2});
        data_exp.push_back(mem_word(32'h0000_2000));
        tick();
        data_sram_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        send_r(4'd1, mem_word(32'h0000_2000));
        last_data_rdata = mem_word(32'h0000_2000);
        drain("write_then_read");
    endtask

    task automatic test_ar_stall();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0200; inst_sram_size = 2'd2;
        #1;
        checks++;
        if (inst_sram_addr_ok !== 1'b1) begin
            errors++; $display("FAIL stall_accept: got %b required 1", inst_sram_addr_ok);
        end
        ar_exp.push_back({4'd0, 32'h1C00_0200, 3'd2});
        inst_exp.push_back(mem_word(32'h1C00_0200));
        for (int i = 0; i < 5; i++) begin
            tick();
            inst_sram_addr = 32'h1C00_0300 + 32'(i);
            #1;
            checks++;
            if ({arvalid, arid, araddr, inst_sram_addr_ok} !== {1'b1, 4'd0, 32'h1C00_0200, 1'b0}) begin
                errors++;
                $display("FAIL stall_cycle%0d: got v=%b id=%h addr=%h addr_ok=%b required 1 0 1c000200 0",
                         i, arvalid, arid, araddr, inst_sram_addr_ok);
            end
        end
        arready = 1'b1; inst_sram_req = 1'b0;
        tick();
        arready = 1'b0;
        send_r(4'd0, mem_word(32'h1C00_0200));
        drain("ar_stall");
    endtask

    task automatic test_reset_mid();
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_3000; data_sram_size = 2'd2;
        #1;
        checks++;
        if (data_sram_addr_ok !== 1'b1) begin
            errors++; $display("FAIL rst_mid_accept: got %b required 1", data_sram_addr_ok);
        end
        ar_exp.push_back({4'd1, 32'h0000_3000, 3'd2});
        data_exp.push_back(mem_word(32'h0000_3000));
        tick();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({arvalid, awvalid, wvalid, data_sram_addr_ok} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_async: got arv/awv/wv/addr_ok=%b required 0000",
                               {arvalid, awvalid, wvalid, data_sram_addr_ok});
        end
        ar_exp.delete();
        data_exp.delete();
        data_sram_req = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        send_r(4'd1, 32'hBAD0_0001);
        tick(); tick(); tick();
        data_sram_req = 1'b1;
        #1;
        checks++;
        if (data_sram_addr_ok !== 1'b1) begin
            errors++; $display("FAIL rst_recover_accept: got %b required 1", data_sram_addr_ok);
        end
        ar_exp.push_back({4'd1, 32'h0000_3000, 3'd2});
        data_exp.push_back(mem_word(32'h0000_3000));
        tick();
        data_sram_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        send_r(4'd1, mem_word(32'h0000_3000));
        drain("reset_mid");
    endtask

    initial begin
        resetn = 1'b0;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
        inst_sram_wstrb = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
        data_sram_wstrb = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rid = 4'hF; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
        bid = 4'hF; bresp = 2'b00; bvalid = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_inst_read();
        test_dual_read();
        test_write_then_read();
        test_ar_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 SHALL have parameter INST_ID, default 4'd0: AXI ID used for instruction-port reads.
REQ-002 SHALL have parameter DATA_ID, default 4'd1: AXI ID used for data-port reads and writes.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 inst_sram_{req,wr,size,wstrb,addr,wdata}  in  1/1/2/4/32/32  core instruction request.
REQ-006 inst_sram_{addr_ok,data_ok,rdata}  out  1/1/32  instruction accept, return pulse, return data.
REQ-007 data_sram_{req,wr,size,wstrb,addr,wdata}  in  1/1/2/4/32/32  core data request.
REQ-008 data_sram_{addr_ok,data_ok,rdata}  out  1/1/32  data accept, return pulse, return data.
REQ-009 ar{id,addr,len,size,burst,lock,cache,prot,valid}  out  4/32/8/3/2/2/4/3/1, arready in 1: AXI read address.
REQ-010 r{id,data,resp,last,valid}  in  4/32/2/1/1, rready out 1: AXI read data.
REQ-011 aw{id,addr,len,size,burst,lock,cache,prot,valid}  out  as AR, awready in 1: AXI write address.
REQ-012 w{id,data,strb,last,valid}  out  4/32/4/1/1, wready in 1: AXI write data.
REQ-013 b{id,resp,valid}  in  4/2/1, bready out 1: AXI write response.

Function
REQ-014 Constant outputs SHALL be: arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1, wid=awid=DATA_ID, rready=1, bready=1.
REQ-015 arsize/awsize SHALL equal {1'b0, sram_size} of the captured request.
REQ-016 inst_sram_wr SHALL be ignored; instruction requests are reads.
REQ-017 addr_ok SHALL be combinational: asserted in the same cycle as req when the accept condition holds; request fields captured on that edge.
REQ-018 Instruction read accept: AR slot empty, no instruction read outstanding, data port not accepted this cycle.
REQ-019 Data read accept: AR slot empty, no data read outstanding, write FSM in W_IDLE.
REQ-020 Data write accept: write FSM in W_IDLE, no data read outstanding (in AR slot or awaiting R).
REQ-021 Simultaneous instruction and data read requests: data SHALL win; inst addr_ok held low that cycle.
REQ-022 AR slot: arvalid SHALL rise the cycle after accept, hold addr/id/size stable until arvalid&&arready, then clear; on handshake the per-ID outstanding flag sets.
REQ-023 On rvalid with rid==INST_ID: inst outstanding flag clears; next cycle inst_sram_data_ok=1 for exactly one cycle with inst_sram_rdata=rdata.
REQ-024 On rvalid with rid==DATA_ID: same behaviour on the data port.
REQ-025 Write FSM states: W_IDLE -> W_SEND on accept (awvalid and wvalid both rise next cycle); each drops independently on its own handshake; W_SEND -> W_RESP when both done; W_RESP -> W_IDLE on bvalid, with data_sram_data_ok pulsed the following cycle (rdata unchanged).
REQ-026 awready and wready in any order or the same cycle SHALL be handled; no channel re-asserted after its handshake.
REQ-027 rresp/bresp SHALL be ignored; responses with unknown IDs SHALL be dropped.
REQ-028 data_ok pulses SHALL never coincide with addr_ok for the same port in a way that loses a return; at most one outstanding transaction per port.

Reset
REQ-029 During reset: arvalid, awvalid, wvalid, both addr_ok, both data_ok = 0; rdata outputs = 0; write FSM = W_IDLE; all outstanding flags = 0.
REQ-030 Reset mid-transaction SHALL discard all in-flight state; no transaction is replayed after release.

Structure
REQ-031 Write-FSM state encoding and AXI constant values (burst INCR, default IDs) SHALL live in the shared defines header.
REQ-032 Single module; no sub-modules; top-level instantiates it beside the core.

Verification
REQ-033 Inst read 0x1C000000, arready=1 immediate, rvalid 3 cycles later with rid=0, rdata=0x02800C0C -> addr_ok same cycle as req, arvalid 1 cycle, inst data_ok one-cycle pulse with 0x02800C0C.
REQ-034 Inst and data reads same cycle -> data addr_ok=1, inst addr_ok=0; ARs issued data (id 1) then inst (id 0); out-of-order R (id 0 first) routed to correct ports.
REQ-035 Data write addr 0x8000_0010, wstrb 4'b0011, size 1 -> awsize=1, wstrb=0011; awready 2 cycles before wready -> each valid drops on own handshake; data_ok one cycle after bvalid.
REQ-036 Data read requested while write in W_RESP -> addr_ok held 0 until FSM back in W_IDLE, then accepted.
REQ-037 arvalid high with arready=0 for 5 cycles -> araddr/arid stable throughout; no second accept.
REQ-038 resetn pulled low while data read outstanding -> all valids 0 asynchronously; late rvalid id 1 after release produces no data_ok.
